// File: rtl/tcm_boot_loader.sv
// Purpose : copies a byte stream into TCM as little-endian words, optionally verifying each word by read-back.
// Latency : one stream byte per cycle in COLLECT; each word costs a write (and read) request/ack round trip.
// Backpres: in_ready_o is high only while collecting bytes; bus requests are held stable until mem_d_accept_i.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), asynchronous active-low reset
//   start_i, len_i                start a load of len_i bytes (ignored while busy_o)
//   in_valid_i/in_data_i/in_ready_o  byte stream in
//   mem_d_*                       single-outstanding request/accept/ack data port initiator
//   busy_o, done_o, error_o       load status (done/error sticky until next accepted start)
//   core_rst_o                    core reset, released only after an error-free load
module tcm_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          VERIFY    = 1,
  parameter int          TIMEOUT   = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] len_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic [31:0] mem_d_addr_o,
  output logic [31:0] mem_d_data_wr_o,
  output logic        mem_d_rd_o,
  output logic [3:0]  mem_d_wr_o,
  input  logic        mem_d_accept_i,
  input  logic        mem_d_ack_i,
  input  logic [31:0] mem_d_data_rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        core_rst_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WREQ,
    S_WACK,
    S_RREQ,
    S_RACK,
    S_DONE
  } state_t;

  // Last count value before the wait is abandoned: TIMEOUT cycles spent in one wait state.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] tmo_q, tmo_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  idx_q, idx_d;
  logic        error_q, error_d;

  logic [31:0] byte_mask;
  logic        tmo_hit;
  logic        wr_done;
  logic        rd_done;
  logic        word_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      strb_q      <= '0;
      idx_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      strb_q      <= strb_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    idx_d       = idx_q;
    error_d     = error_q;
    wr_done     = 1'b0;
    rd_done     = 1'b0;
    word_next   = 1'b0;
    byte_mask   = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
    tmo_hit     = (tmo_q >= TMO_LAST);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          remaining_d = len_i;
          addr_d      = BASE_ADDR;
          data_d      = '0;
          strb_d      = '0;
          idx_d       = '0;
          error_d     = 1'b0;
          state_d     = (len_i == 32'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid_i) begin
          data_d[{idx_q, 3'b000} +: 8] = in_data_i;
          strb_d[idx_q]                = 1'b1;
          remaining_d                  = remaining_q - 32'd1;
          idx_d                        = idx_q + 2'd1;
          // Word is complete on its 4th byte or on the image's final byte.
          if (idx_q == 2'd3 || remaining_q == 32'd1) begin
            state_d = S_WREQ;
          end
        end
      end
      S_WREQ: begin
        if (mem_d_accept_i) begin
          if (mem_d_ack_i) wr_done = 1'b1;
          else             state_d = S_WACK;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WACK: begin
        if (mem_d_ack_i) begin
          wr_done = 1'b1;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RREQ: begin
        if (mem_d_accept_i) begin
          if (mem_d_ack_i) rd_done = 1'b1;
          else             state_d = S_RACK;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RACK: begin
        if (mem_d_ack_i) begin
          rd_done = 1'b1;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_done) begin
      if (VERIFY != 0) state_d = S_RREQ;
      else             word_next = 1'b1;
    end

    // Only the bytes actually written are compared; unwritten lanes hold whatever TCM had.
    if (rd_done) begin
      if (((mem_d_data_rd_i ^ data_q) & byte_mask) != 32'd0) begin
        error_d = 1'b1;
        state_d = S_DONE;
      end else begin
        word_next = 1'b1;
      end
    end

    if (word_next) begin
      addr_d  = addr_q + 32'd4;
      data_d  = '0;
      strb_d  = '0;
      idx_d   = '0;
      state_d = (remaining_q == 32'd0) ? S_DONE : S_COLLECT;
    end

    // Counter restarts on every state change, so each wait state gets its own budget.
    tmo_d = (state_d != state_q) ? 32'd0 : tmo_q + 32'd1;
  end

  assign in_ready_o      = (state_q == S_COLLECT);
  assign mem_d_addr_o    = addr_q;
  assign mem_d_data_wr_o = data_q;
  assign mem_d_wr_o      = (state_q == S_WREQ) ? strb_q : 4'b0000;
  assign mem_d_rd_o      = (state_q == S_RREQ);
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o          = (state_q == S_DONE);
  assign error_o         = error_q;
  assign core_rst_o      = !(done_o && !error_q);

endmodule

// File: tb/tb_tcm_boot_loader.sv
module tb_tcm_boot_loader;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] len_i = '0;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i = '0;
  logic        in_ready_o;
  logic [31:0] mem_d_addr_o;
  logic [31:0] mem_d_data_wr_o;
  logic        mem_d_rd_o;
  logic [3:0]  mem_d_wr_o;
  logic        mem_d_accept_i = 1'b0;
  logic        mem_d_ack_i = 1'b0;
  logic [31:0] mem_d_data_rd_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        core_rst_o;

  always #5 clk_i = ~clk_i;

  tcm_boot_loader #(.BASE_ADDR(BASE), .VERIFY(1), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .mem_d_addr_o(mem_d_addr_o), .mem_d_data_wr_o(mem_d_data_wr_o),
    .mem_d_rd_o(mem_d_rd_o), .mem_d_wr_o(mem_d_wr_o),
    .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i),
    .mem_d_data_rd_i(mem_d_data_rd_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .core_rst_o(core_rst_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- responder / TCM model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic [31:0] mem [logic [31:0]];
  wr_t         wlog[$];
  int          acc_delay = 0;
  bit          same_ack = 0;
  bit          no_ack = 0;
  int          corrupt_word = -1;
  int          stab_err = 0;
  int          rw_err = 0;
  int          req_cnt = 0;
  int          wait_cnt = 0;
  bit          pend = 0;
  logic [31:0] pend_dat = '0;
  logic [68:0] held = '0;

  always @(negedge clk_i) begin
    logic [31:0] w;
    logic [31:0] rdat;
    mem_d_accept_i  = 1'b0;
    mem_d_ack_i     = 1'b0;
    mem_d_data_rd_i = '0;
    if (!rst_i) begin
      pend     = 0;
      wait_cnt = 0;
    end else begin
      if (pend) begin
        mem_d_ack_i     = 1'b1;
        mem_d_data_rd_i = pend_dat;
        pend            = 0;
      end
      if (mem_d_rd_o && mem_d_wr_o != 4'b0) rw_err++;
      if (mem_d_rd_o || mem_d_wr_o != 4'b0) begin
        if (wait_cnt == 0) held = {mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o};
        else if (held != {mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o}) stab_err++;
        if (wait_cnt < acc_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt       = 0;
          req_cnt++;
          mem_d_accept_i = 1'b1;
          w = mem.exists(mem_d_addr_o) ? mem[mem_d_addr_o] : 32'hDEAD_BEEF;
          if (mem_d_wr_o != 4'b0) begin
            for (int k = 0; k < 4; k++)
              if (mem_d_wr_o[k]) w[8*k +: 8] = mem_d_data_wr_o[8*k +: 8];
            mem[mem_d_addr_o] = w;
            wlog.push_back('{a: mem_d_addr_o, d: mem_d_data_wr_o, s: mem_d_wr_o});
            rdat = '0;
          end else begin
            rdat = w;
            if (corrupt_word >= 0 && ((mem_d_addr_o - BASE) >> 2) == 32'(corrupt_word))
              rdat[0] = ~rdat[0];
          end
          if (!no_ack) begin
            if (same_ack) begin
              mem_d_ack_i     = 1'b1;
              mem_d_data_rd_i = rdat;
            end else begin
              pend     = 1;
              pend_dat = rdat;
            end
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- stimulus + reference ----------------
  logic [7:0] img[$];
  int         log_base;
  int         req_base;

  // Start a load, stream the image with random gaps, wait for done_o.
  task automatic run_load(input int len, input bit fixed, input int gap_pct,
                          input int mid_start_at, output int cycles, output logic err_after_start);
    int fed;
    img.delete();
    for (int i = 0; i < len; i++) img.push_back(fixed ? 8'(i) : 8'($urandom));
    log_base = wlog.size();
    req_base = req_cnt;
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = 32'(len);
    @(negedge clk_i);
    start_i = 1'b0;
    err_after_start = error_o;
    fed    = 0;
    cycles = 0;
    while (!done_o && cycles < 500) begin
      start_i = (cycles == mid_start_at);
      len_i   = (cycles == mid_start_at) ? 32'd4 : 32'(len);
      if (fed < len && int'($urandom_range(99)) >= gap_pct) begin
        in_valid_i = 1'b1;
        in_data_i  = img[fed];
      end else begin
        in_valid_i = 1'b0;
      end
      if (in_valid_i && in_ready_o) fed++;
      @(negedge clk_i);
      cycles++;
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    chk("load_terminates", 32'(cycles < 500), 32'd1);
  endtask

  // Expected write sequence derived from the image: word w covers bytes 4w..4w+3.
  task automatic check_writes(input string tag, input int n_words);
    int got;
    logic [31:0] ed;
    logic [3:0]  es;
    got = wlog.size() - log_base;
    chk({tag, "_nwrites"}, 32'(got), 32'(n_words));
    for (int w = 0; w < n_words && w < got; w++) begin
      ed = '0;
      es = '0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < img.size()) begin
          ed = ed | (32'(img[4*w+k]) << (8*k));
          es[k] = 1'b1;
        end
      chk($sformatf("%s_w%0d_addr", tag, w), wlog[log_base+w].a, BASE + 32'(4*w));
      chk($sformatf("%s_w%0d_data", tag, w), wlog[log_base+w].d, ed);
      chk($sformatf("%s_w%0d_strb", tag, w), 32'(wlog[log_base+w].s), 32'(es));
    end
  endtask

  task automatic check_status(input string tag, input logic exp_err);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_error"}, 32'(error_o), 32'(exp_err));
    chk({tag, "_core_rst"}, 32'(core_rst_o), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    chk({tag, "_rd"}, 32'(mem_d_rd_o), 32'd0);
    chk({tag, "_wr"}, 32'(mem_d_wr_o), 32'd0);
    chk({tag, "_addr"}, mem_d_addr_o, 32'd0);
    chk({tag, "_data"}, mem_d_data_wr_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_error"}, 32'(error_o), 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst_o), 32'd1);
  endtask

  initial begin
    int   cyc;
    int   len;
    int   n;
    logic e0;

    // Reset state
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;

    // 1: eight bytes 00..07, ack one cycle after accept
    run_load(8, 1, 0, -1, cyc, e0);
    check_writes("t1", 2);
    chk("t1_w0_const", wlog[log_base].d, 32'h0302_0100);
    chk("t1_w1_const", wlog[log_base+1].d, 32'h0706_0504);
    check_status("t1", 1'b0);

    // 2: partial last word; TCM upper bytes differ from written data, verify must mask them
    run_load(6, 1, 0, -1, cyc, e0);
    check_writes("t2", 2);
    chk("t2_w1_strb_const", 32'(wlog[log_base+1].s), 32'h3);
    check_status("t2", 1'b0);

    // 3: corrupt read-back of word 1 -> abort, word 2 never written
    corrupt_word = 1;
    run_load(12, 0, 0, -1, cyc, e0);
    corrupt_word = -1;
    check_writes("t3", 2);
    check_status("t3", 1'b1);

    // 4: accept withheld 5 cycles, same-cycle ack, gapped stream
    acc_delay = 5;
    same_ack  = 1;
    n = stab_err;
    run_load(10, 0, 40, -1, cyc, e0);
    check_writes("t4", 3);
    check_status("t4", 1'b0);
    chk("t4_req_stable", 32'(stab_err - n), 32'd0);
    acc_delay = 0;
    same_ack  = 0;

    // 5: no ack -> timeout; start mid-load ignored; next start clears error
    no_ack = 1;
    run_load(8, 0, 0, 5, cyc, e0);
    no_ack = 0;
    check_writes("t5", 1);
    check_status("t5", 1'b1);
    chk("t5_waited_timeout", 32'(cyc >= 15), 32'd1);
    run_load(5, 0, 0, -1, cyc, e0);
    chk("t5_error_cleared_by_start", 32'(e0), 32'd0);
    check_writes("t5b", 2);
    check_status("t5b", 1'b0);

    // Randomised loads against the reference
    for (int it = 0; it < 6; it++) begin
      len       = int'($urandom_range(1, 13));
      acc_delay = int'($urandom_range(0, 3));
      same_ack  = 1'($urandom_range(0, 1));
      run_load(len, 0, int'($urandom_range(0, 50)), -1, cyc, e0);
      check_writes($sformatf("rnd%0d", it), (len + 3) / 4);
      check_status($sformatf("rnd%0d", it), 1'b0);
    end
    acc_delay = 0;
    same_ack  = 0;

    // 6a: zero length -> done next cycle, no bus traffic
    run_load(0, 0, 0, -1, cyc, e0);
    chk("t6_len0_cycles", 32'(cyc), 32'd0);
    chk("t6_len0_no_traffic", 32'(req_cnt - req_base), 32'd0);
    check_status("t6_len0", 1'b0);

    // 6b: reset while a write request is pending
    acc_delay = 1000;
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = 32'd4;
    @(negedge clk_i);
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 8'hA5;
    cyc = 0;
    while (mem_d_wr_o == 4'b0 && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("t6_reached_wreq", 32'(mem_d_wr_o), 32'hF);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("t6_midreset");
    @(negedge clk_i);
    rst_i     = 1'b1;
    acc_delay = 0;

    chk("no_rd_wr_overlap", 32'(rw_err), 32'd0);
    chk("req_stable_all", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
